present_cipher_core: RTL and testbench

- Iterative PRESENT block-cipher core: one round per clock, key schedule computed on the fly, no stored round-key table.
- Parametrised successor to the team's fixed 80-bit encryptor: adds 128-bit key support, a configurable round count, a start/busy/done handshake, and an optional decrypt mode.
- Sits between the key/plaintext source registers and the downstream result register.

---
 rtl/present_cipher_core_if.sv | 24 ++
 rtl/present_cipher_core.sv | 180 ++++++++++++++++++
 tb/tb_present_cipher_core.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/present_cipher_core_if.sv
// Purpose: handshake/data bundle between the key/plaintext source and the PRESENT core.
// Ports: start/key/data_in (and mode with PRESENT_DECRYPT_EN) toward the core;
//        busy/done/data_out back to the requester. master = requester, slave = core.
interface present_cipher_core_if #(
  parameter int KEY_WIDTH = 80
);
  logic                 start;
  logic [KEY_WIDTH-1:0] key;
  logic [63:0]          data_in;
`ifdef PRESENT_DECRYPT_EN
  logic                 mode;
`endif
  logic                 busy;
  logic                 done;
  logic [63:0]          data_out;

`ifdef PRESENT_DECRYPT_EN
  modport master (output start, key, data_in, mode, input busy, done, data_out);
  modport slave  (input start, key, data_in, mode, output busy, done, data_out);
`else
  modport master (output start, key, data_in, input busy, done, data_out);
  modport slave  (input start, key, data_in, output busy, done, data_out);
`endif
endinterface

// File: rtl/present_cipher_core.sv
// Purpose: iterative PRESENT block cipher, one round per clock, round keys derived on the fly.
// Ports: i_clock, i_reset_n (async active-low), io_bus (slave side of present_cipher_core_if).
// Optional decrypt path (mode input, KEYEXP/DEC states) is built only when PRESENT_DECRYPT_EN is defined.
module present_cipher_core #(
  parameter int KEY_WIDTH = 80,
  parameter int ROUNDS    = 31
) (
  input  logic                  i_clock,
  input  logic                  i_reset_n,
  present_cipher_core_if.slave  io_bus
);

  if (KEY_WIDTH != 80 && KEY_WIDTH != 128) begin : g_bad_key_width
    $error("present_cipher_core: KEY_WIDTH must be 80 or 128");
  end
  if (ROUNDS < 1 || ROUNDS > 31) begin : g_bad_rounds
    $error("present_cipher_core: ROUNDS must be in 1..31");
  end

  // Nibble tables, entry n sits at bits [4n+3:4n].
  localparam logic [63:0] SBOX_TAB = 64'h21748FE3DA09B65C;
  // Bit position where the round counter is folded into the key register.
  localparam int          RC_LSB   = (KEY_WIDTH == 128) ? 62 : 15;
  localparam logic [4:0]  RC_LAST  = 5'(ROUNDS);

`ifdef PRESENT_DECRYPT_EN
  localparam logic [63:0] INV_SBOX_TAB = 64'hA970364BD21C8FE5;
  typedef enum logic [2:0] {ST_IDLE, ST_ENC, ST_FINAL, ST_KEYEXP, ST_DEC} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_ENC, ST_FINAL} state_t;
`endif

  function automatic logic [3:0] sbox(input logic [3:0] x);
    return SBOX_TAB[{x, 2'b00} +: 4];
  endfunction

  function automatic logic [63:0] s_layer(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int n = 0; n < 16; n++) y[4*n +: 4] = sbox(x[4*n +: 4]);
    return y;
  endfunction

  function automatic logic [63:0] p_layer(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 63; i++) y[(16*i) % 63] = x[i];
    y[63] = x[63];
    return y;
  endfunction

  // One step of the forward key schedule: K_i -> K_(i+1) using counter rc = i.
  function automatic logic [KEY_WIDTH-1:0] key_fwd(input logic [KEY_WIDTH-1:0] k,
                                                   input logic [4:0] rc);
    logic [KEY_WIDTH-1:0] t;
    t = (k << 61) | (k >> (KEY_WIDTH - 61));
    t[KEY_WIDTH-1 -: 4] = sbox(t[KEY_WIDTH-1 -: 4]);
    if (KEY_WIDTH == 128) t[KEY_WIDTH-5 -: 4] = sbox(t[KEY_WIDTH-5 -: 4]);
    t[RC_LSB +: 5] = t[RC_LSB +: 5] ^ rc;
    return t;
  endfunction

`ifdef PRESENT_DECRYPT_EN
  function automatic logic [3:0] inv_sbox(input logic [3:0] x);
    return INV_SBOX_TAB[{x, 2'b00} +: 4];
  endfunction

  function automatic logic [63:0] inv_s_layer(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int n = 0; n < 16; n++) y[4*n +: 4] = inv_sbox(x[4*n +: 4]);
    return y;
  endfunction

  function automatic logic [63:0] inv_p_layer(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 63; i++) y[i] = x[(16*i) % 63];
    y[63] = x[63];
    return y;
  endfunction

  // Exact inverse of key_fwd: K_(i+1) -> K_i using counter rc = i.
  function automatic logic [KEY_WIDTH-1:0] key_inv(input logic [KEY_WIDTH-1:0] k,
                                                   input logic [4:0] rc);
    logic [KEY_WIDTH-1:0] t;
    t = k;
    t[RC_LSB +: 5] = t[RC_LSB +: 5] ^ rc;
    t[KEY_WIDTH-1 -: 4] = inv_sbox(t[KEY_WIDTH-1 -: 4]);
    if (KEY_WIDTH == 128) t[KEY_WIDTH-5 -: 4] = inv_sbox(t[KEY_WIDTH-5 -: 4]);
    return (t >> 61) | (t << (KEY_WIDTH - 61));
  endfunction
`endif

  state_t               r_state;
  logic [63:0]          r_s;
  logic [KEY_WIDTH-1:0] r_k;
  logic [4:0]           r_rc;
  logic                 r_busy;
  logic                 r_done;
  logic [63:0]          r_data_out;

  logic [63:0]          w_round_key;
  logic [63:0]          w_enc_s;
  logic [KEY_WIDTH-1:0] w_key_fwd;

  assign w_round_key = r_k[KEY_WIDTH-1 -: 64];
  assign w_enc_s     = p_layer(s_layer(r_s ^ w_round_key));
  assign w_key_fwd   = key_fwd(r_k, r_rc);

`ifdef PRESENT_DECRYPT_EN
  logic [63:0]          w_dec_s;
  logic [KEY_WIDTH-1:0] w_key_inv;
  // In DEC, r_k holds K_(rc+1) on entry to each step.
  assign w_dec_s   = inv_s_layer(inv_p_layer(r_s ^ w_round_key));
  assign w_key_inv = key_inv(r_k, r_rc);
`endif

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state    <= ST_IDLE;
      r_s        <= '0;
      r_k        <= '0;
      r_rc       <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_data_out <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (io_bus.start) begin
            r_s    <= io_bus.data_in;
            r_k    <= io_bus.key;
            r_rc   <= 5'd1;
            r_busy <= 1'b1;
`ifdef PRESENT_DECRYPT_EN
            r_state <= io_bus.mode ? ST_KEYEXP : ST_ENC;
`else
            r_state <= ST_ENC;
`endif
          end
        end
        ST_ENC: begin
          r_s <= w_enc_s;
          r_k <= w_key_fwd;
          if (r_rc == RC_LAST) r_state <= ST_FINAL;
          else                 r_rc    <= r_rc + 5'd1;
        end
`ifdef PRESENT_DECRYPT_EN
        // Run the schedule forward to K_(ROUNDS+1); rc then stays at ROUNDS to count back down.
        ST_KEYEXP: begin
          r_k <= w_key_fwd;
          if (r_rc == RC_LAST) r_state <= ST_DEC;
          else                 r_rc    <= r_rc + 5'd1;
        end
        ST_DEC: begin
          r_s <= w_dec_s;
          r_k <= w_key_inv;
          if (r_rc == 5'd1) r_state <= ST_FINAL;
          else              r_rc    <= r_rc - 5'd1;
        end
`endif
        ST_FINAL: begin
          // Encrypt: r_k = K_(ROUNDS+1); decrypt: r_k = K_1. Same whitening either way.
          r_data_out <= r_s ^ w_round_key;
          r_done     <= 1'b1;
          r_busy     <= 1'b0;
          r_state    <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign io_bus.busy     = r_busy;
  assign io_bus.done     = r_done;
  assign io_bus.data_out = r_data_out;

endmodule

// File: tb/tb_present_cipher_core.sv
// Purpose: directed check of present_cipher_core (80-bit, 128-bit and 1-round builds).
// Expected results are queued when a request is issued and compared when done pulses.
module tb_present_cipher_core;

  logic        clk = 1'b0;
  logic        rst_n;
  int unsigned cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] data;
    int unsigned at;
  } exp_t;

  exp_t q80[$];
  exp_t q128[$];
  exp_t qr1[$];

`ifdef PRESENT_DECRYPT_EN
  logic dec_mode = 1'b0;
`endif

  present_cipher_core_if #(.KEY_WIDTH(80))  bus80();
  present_cipher_core_if #(.KEY_WIDTH(128)) bus128();
  present_cipher_core_if #(.KEY_WIDTH(80))  busr1();

  present_cipher_core #(.KEY_WIDTH(80),  .ROUNDS(31)) u_dut80  (.i_clock(clk), .i_reset_n(rst_n), .io_bus(bus80));
  present_cipher_core #(.KEY_WIDTH(128), .ROUNDS(31)) u_dut128 (.i_clock(clk), .i_reset_n(rst_n), .io_bus(bus128));
  present_cipher_core #(.KEY_WIDTH(80),  .ROUNDS(1))  u_dutr1  (.i_clock(clk), .i_reset_n(rst_n), .io_bus(busr1));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request from the current negedge; optionally queue the expected result.
  task automatic go80(input logic [79:0] k, input logic [63:0] d, input logic [63:0] e,
                      input int lat, input bit push);
    exp_t t;
    bus80.start = 1'b1; bus80.key = k; bus80.data_in = d;
`ifdef PRESENT_DECRYPT_EN
    bus80.mode = dec_mode;
`endif
    t.data = e; t.at = cyc + 1 + lat;
    if (push) q80.push_back(t);
    @(negedge clk);
    bus80.start = 1'b0;
  endtask

  task automatic go128(input logic [127:0] k, input logic [63:0] d, input logic [63:0] e,
                       input int lat);
    exp_t t;
    bus128.start = 1'b1; bus128.key = k; bus128.data_in = d;
`ifdef PRESENT_DECRYPT_EN
    bus128.mode = dec_mode;
`endif
    t.data = e; t.at = cyc + 1 + lat;
    q128.push_back(t);
    @(negedge clk);
    bus128.start = 1'b0;
  endtask

  task automatic gor1(input logic [79:0] k, input logic [63:0] d, input logic [63:0] e);
    exp_t t;
    busr1.start = 1'b1; busr1.key = k; busr1.data_in = d;
`ifdef PRESENT_DECRYPT_EN
    busr1.mode = 1'b0;
`endif
    t.data = e; t.at = cyc + 1 + 2;
    qr1.push_back(t);
    @(negedge clk);
    busr1.start = 1'b0;
  endtask

  // Scoreboard side: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin : mon80
    exp_t e;
    if (bus80.done === 1'b1) begin
      if (q80.size() == 0) chk("dut80_unexpected_done", 64'(bus80.done), 64'd0);
      else begin
        e = q80.pop_front();
        chk("dut80_data", bus80.data_out, e.data);
        chk("dut80_done_cycle", 64'(cyc), 64'(e.at));
      end
    end
  end

  always @(negedge clk) begin : mon128
    exp_t e;
    if (bus128.done === 1'b1) begin
      if (q128.size() == 0) chk("dut128_unexpected_done", 64'(bus128.done), 64'd0);
      else begin
        e = q128.pop_front();
        chk("dut128_data", bus128.data_out, e.data);
        chk("dut128_done_cycle", 64'(cyc), 64'(e.at));
      end
    end
  end

  always @(negedge clk) begin : monr1
    exp_t e;
    if (busr1.done === 1'b1) begin
      if (qr1.size() == 0) chk("dutr1_unexpected_done", 64'(busr1.done), 64'd0);
      else begin
        e = qr1.pop_front();
        chk("dutr1_data", busr1.data_out, e.data);
        chk("dutr1_done_cycle", 64'(cyc), 64'(e.at));
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    bus80.start  = 1'b0; bus80.key  = '0; bus80.data_in  = '0;
    bus128.start = 1'b0; bus128.key = '0; bus128.data_in = '0;
    busr1.start  = 1'b0; busr1.key  = '0; busr1.data_in  = '0;
`ifdef PRESENT_DECRYPT_EN
    bus80.mode = 1'b0; bus128.mode = 1'b0; busr1.mode = 1'b0;
`endif
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_busy",     64'(bus80.busy), 64'd0);
    chk("rst_done",     64'(bus80.done), 64'd0);
    chk("rst_data_out", bus80.data_out,  64'd0);
    chk("rst_busy128",  64'(bus128.busy), 64'd0);
    chk("rst_data_r1",  busr1.data_out,  64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 80-bit all-zero vector, with busy/done profile over the 31 round cycles
    go80(80'h0, 64'h0, 64'h5579C1387B228445, 32, 1'b1);
    for (int k = 1; k <= 31; k++) begin
      @(negedge clk);
      chk("t1_busy_running", 64'(bus80.busy), 64'd1);
      chk("t1_done_early",   64'(bus80.done), 64'd0);
    end
    @(negedge clk);
    chk("t1_busy_at_done", 64'(bus80.busy), 64'd0);
    repeat (3) @(negedge clk);

    // 80-bit all-ones vector; a second start mid-run (with new inputs) must be ignored
    go80({80{1'b1}}, {64{1'b1}}, 64'h3333DCD3213210D2, 32, 1'b1);
    repeat (9) @(negedge clk);
    go80(80'h0, 64'h0, 64'h0, 0, 1'b0);
    bus80.key = 80'h12345; bus80.data_in = 64'hDEADBEEF;
    for (int k = 0; k < 40 && bus80.done !== 1'b1; k++) @(negedge clk);
    // Back-to-back: start during the done cycle
    go80(80'h0, 64'h0, 64'h5579C1387B228445, 32, 1'b1);
    repeat (40) @(negedge clk);

    // 128-bit key, then back-to-back restart
    go128(128'h0, 64'h0, 64'h96DB702A2E6900AF, 32);
    for (int k = 0; k < 40 && bus128.done !== 1'b1; k++) @(negedge clk);
    go128(128'h0, 64'h0, 64'h96DB702A2E6900AF, 32);
    repeat (40) @(negedge clk);

    // Reset at cycle ~10 of an operation: outputs clear at once, no done follows
    go80(80'h0, 64'h0, 64'h0, 0, 1'b0);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy",     64'(bus80.busy), 64'd0);
    chk("midrst_done",     64'(bus80.done), 64'd0);
    chk("midrst_data_out", bus80.data_out,  64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    go80(80'h0, 64'h0, 64'h5579C1387B228445, 32, 1'b1);
    repeat (40) @(negedge clk);

    // Single-round build
    gor1(80'h0, 64'h0, 64'h3FFFFFFF00000000);
    repeat (4) @(negedge clk);
    gor1(80'h0, {64{1'b1}}, 64'hC0000000FFFF0000);
    repeat (4) @(negedge clk);

`ifdef PRESENT_DECRYPT_EN
    dec_mode = 1'b1;
    go80(80'h0, 64'h5579C1387B228445, 64'h0, 63, 1'b1);
    repeat (70) @(negedge clk);
    go80({80{1'b1}}, 64'h3333DCD3213210D2, {64{1'b1}}, 63, 1'b1);
    repeat (70) @(negedge clk);
    go128(128'h0, 64'h96DB702A2E6900AF, 64'h0, 63);
    repeat (70) @(negedge clk);
    dec_mode = 1'b0;
    go80(80'h0, 64'h0, 64'h5579C1387B228445, 32, 1'b1);
    repeat (40) @(negedge clk);
`endif

    // Every queued request must have produced its done
    chk("pending80",  64'(q80.size()),  64'd0);
    chk("pending128", 64'(q128.size()), 64'd0);
    chk("pendingr1",  64'(qr1.size()),  64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
